// File: rtl/simon_decrypt.sv
// ----------------------------------------------------------------------------
// simon_decrypt
//   Iterative Simon32/64 decryption core. A request first forward-expands the
//   key schedule until the four-word window holds k28..k31, then runs the 32
//   inverse rounds while regenerating the round keys backward on the fly, so
//   no round-key storage beyond the window is needed.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    decryption request, sampled only in IDLE or DONE
//   key_in   64-bit key {k3,k2,k1,k0}, k0 in bits [15:0]
//   ct_in    ciphertext {x,y}, x in the upper half, captured with start
//   busy     high while expanding keys or decrypting
//   done     one-cycle pulse when pt_out becomes valid
//   pt_out   plaintext {x,y}, held until the next accepted start
// ----------------------------------------------------------------------------
module simon_decrypt #(
    parameter int unsigned WORD   = 16,
    parameter int unsigned ROUNDS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [4*WORD-1:0] key_in,
    input  logic [2*WORD-1:0] ct_in,
    output logic              busy,
    output logic              done,
    output logic [2*WORD-1:0] pt_out
);

    localparam int unsigned CNT_W = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] CNT_LAST_EXP = CNT_W'(ROUNDS - 5);
    localparam logic [CNT_W-1:0] CNT_TOP      = CNT_W'(ROUNDS - 1);
    localparam logic [WORD-1:0]  C_CONST      = {{(WORD-2){1'b1}}, 2'b00};
    // z0 sequence; index 0 is the leftmost (most significant) bit.
    localparam logic [61:0] Z_SEQ =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v,
                                            input int unsigned j);
        return (v << j) | (v >> (WORD - j));
    endfunction

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v,
                                            input int unsigned j);
        return rol(v, WORD - j);
    endfunction

    function automatic logic [WORD-1:0] f_round(input logic [WORD-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    state_t            state_q, state_d;
    logic [WORD-1:0]   w0_q, w1_q, w2_q, w3_q;
    logic [WORD-1:0]   w0_d, w1_d, w2_d, w3_d;
    logic [WORD-1:0]   x_q, y_q, x_d, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2*WORD-1:0] pt_q, pt_d;

    logic [5:0]        z_idx;
    logic              z_bit;
    logic [WORD-1:0]   z_word;
    logic [WORD-1:0]   t_fwd, t_bwd;
    logic [WORD-1:0]   key_new, key_prev;
    logic [WORD-1:0]   y_next;

    // Forward step reads z[cnt]; backward step for round i reads z[i-4].
    // Below i = 4 the regenerated key is never used, so any index will do.
    always_comb begin
        z_idx = 6'(cnt_q);
        if (state_q == DECRYPT) begin
            z_idx = (cnt_q >= CNT_W'(4)) ? (6'(cnt_q) - 6'd4) : '0;
        end
        z_bit  = Z_SEQ[6'd61 - z_idx];
        z_word = {{(WORD-1){1'b0}}, z_bit};

        t_fwd    = ror(w3_q, 3) ^ w1_q;
        key_new  = w0_q ^ C_CONST ^ z_word ^ t_fwd ^ ror(t_fwd, 1);

        t_bwd    = ror(w2_q, 3) ^ w0_q;
        key_prev = w3_q ^ C_CONST ^ z_word ^ t_bwd ^ ror(t_bwd, 1);

        y_next   = x_q ^ f_round(y_q) ^ w3_q;
    end

    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    w0_d    = key_in[WORD-1:0];
                    w1_d    = key_in[2*WORD-1:WORD];
                    w2_d    = key_in[3*WORD-1:2*WORD];
                    w3_d    = key_in[4*WORD-1:3*WORD];
                    x_d     = ct_in[2*WORD-1:WORD];
                    y_d     = ct_in[WORD-1:0];
                    cnt_d   = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                w0_d  = w1_q;
                w1_d  = w2_q;
                w2_d  = w3_q;
                w3_d  = key_new;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST_EXP) begin
                    cnt_d   = CNT_TOP;
                    state_d = DECRYPT;
                end
            end
            DECRYPT: begin
                x_d   = y_q;
                y_d   = y_next;
                w3_d  = w2_q;
                w2_d  = w1_q;
                w1_d  = w0_q;
                w0_d  = key_prev;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    pt_d    = {y_q, y_next};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == EXPAND) || (state_d == DECRYPT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pt_q    <= pt_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign pt_out = pt_q;

endmodule

// File: tb/tb_simon_decrypt.sv
// ----------------------------------------------------------------------------
// tb_simon_decrypt
//   Directed and round-trip bench for simon_decrypt. Expected plaintexts come
//   from the published Simon32/64 vector and from a forward 32-round
//   encryption model with a fully precomputed key schedule.
// ----------------------------------------------------------------------------
module tb_simon_decrypt;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key_in = '0;
    logic [31:0] ct_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] pt_out;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] VKEY = 64'h1918111009080100;
    localparam logic [31:0] VCT  = 32'hC69BE9BB;
    localparam logic [31:0] VPT  = 32'h65656877;

    simon_decrypt #(.WORD(16), .ROUNDS(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .key_in  (key_in),
        .ct_in   (ct_in),
        .busy    (busy),
        .done    (done),
        .pt_out  (pt_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rl(input logic [15:0] v, input int j);
        return (v << j) | (v >> (16 - j));
    endfunction

    function automatic logic [31:0] enc_model(input logic [63:0] k_in,
                                              input logic [31:0] p);
        logic [15:0] k [0:31];
        logic [61:0] zs;
        logic [15:0] t, x, y, tmp;
        zs = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = k_in[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t    = rl(k[i-1], 13) ^ k[i-3];
            k[i] = k[i-4] ^ 16'hFFFC ^ {15'd0, zs[61-(i-4)]} ^ t ^ rl(t, 15);
        end
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    // Issues one request and waits (bounded) for done. lat counts edges from
    // the accepting edge to the edge that raised done.
    task automatic run_op(input logic [63:0] k, input logic [31:0] c,
                          output logic [31:0] pt, output int lat,
                          output int bcnt, output bit ovl);
        start  = 1'b1;
        key_in = k;
        ct_in  = c;
        tick();
        start = 1'b0;
        lat  = 0;
        bcnt = 0;
        ovl  = 1'b0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        if (busy && done) ovl = 1'b1;
        pt = pt_out;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({busy, done, pt_out} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b pt=%h required 0 0 0", busy, done, pt_out);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({busy, done, pt_out} !== 34'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_quiet bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_vector();
        logic [31:0] pt;
        int lat, bcnt;
        bit ovl;
        run_op(VKEY, VCT, pt, lat, bcnt, ovl);
        checks++;
        if (pt !== VPT) begin
            errors++;
            $display("FAIL vector_pt got=%h required %h", pt, VPT);
        end
        checks++;
        if (lat !== 60) begin
            errors++;
            $display("FAIL vector_latency got=%0d required 60", lat);
        end
        checks++;
        if (bcnt !== 60) begin
            errors++;
            $display("FAIL vector_busy_cycles got=%0d required 60", bcnt);
        end
        checks++;
        if (ovl !== 1'b0) begin
            errors++;
            $display("FAIL vector_busy_done_overlap got=%b required 0", ovl);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00 || pt_out !== VPT) begin
            errors++;
            $display("FAIL vector_after_done done=%b busy=%b pt=%h required 0 0 %h", done, busy, pt_out, VPT);
        end
    endtask

    task automatic test_hold_start();
        int pulses = 0;
        logic [31:0] first_pt = '0;
        start  = 1'b1;
        key_in = VKEY;
        ct_in  = VCT;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (i == 50) start = 1'b0;
            if (start) begin
                ct_in  = $urandom;
                key_in = {$urandom, $urandom};
            end
            if (done) begin
                pulses++;
                if (pulses == 1) first_pt = pt_out;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL hold_start_pulses got=%0d required 1", pulses);
        end
        checks++;
        if (first_pt !== VPT) begin
            errors++;
            $display("FAIL hold_start_pt got=%h required %h", first_pt, VPT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pt;
        int lat, bcnt, gap;
        bit ovl;
        bit dropped;
        run_op(VKEY, VCT, pt, lat, bcnt, ovl);
        start  = 1'b1;
        key_in = VKEY;
        ct_in  = VCT;
        tick();
        start   = 1'b0;
        gap     = 1;
        dropped = !done && busy && (pt_out === VPT);
        while (!done && gap < 100) begin
            tick();
            gap++;
        end
        checks++;
        if (dropped !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_in_done_cycle got=%b required 1", dropped);
        end
        checks++;
        if (gap !== 61) begin
            errors++;
            $display("FAIL b2b_period got=%0d required 61", gap);
        end
        checks++;
        if (pt_out !== VPT) begin
            errors++;
            $display("FAIL b2b_pt got=%h required %h", pt_out, VPT);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] pt;
        int lat, bcnt, stray;
        bit ovl;
        start  = 1'b1;
        key_in = 64'h0123456789ABCDEF;
        ct_in  = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        repeat (29) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pt_out} !== 34'd0) begin
            errors++;
            $display("FAIL abort_immediate busy=%b done=%b pt=%h required 0 0 0", busy, done, pt_out);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 3) reset_n = 1'b1;
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL abort_no_done got=%0d required 0", stray);
        end
        run_op(VKEY, VCT, pt, lat, bcnt, ovl);
        checks++;
        if (pt !== VPT || lat !== 60) begin
            errors++;
            $display("FAIL abort_recover pt=%h lat=%0d required %h 60", pt, lat, VPT);
        end
    endtask

    task automatic test_random();
        logic [63:0] k;
        logic [31:0] p, c, got;
        int lat, bcnt, bad;
        bit ovl;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            k = {$urandom, $urandom};
            p = $urandom;
            c = enc_model(k, p);
            run_op(k, c, got, lat, bcnt, ovl);
            checks++;
            if (got !== p || lat !== 60 || ovl) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_roundtrip key=%h ct=%h got=%h lat=%0d required %h 60",
                             k, c, got, lat, p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_vector();
        test_hold_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
